// File: rtl/mgt_pkg.sv
// Shared types and constants for the multi-cycle MGT core: opcodes, FSM
// states, instruction field positions and flag bit indices.
package mgt_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_LD   = 4'd6,
      OP_ST   = 4'd7,
      OP_LI   = 4'd8,
      OP_BEQ  = 4'd9,
      OP_JMP  = 4'd10,
      OP_HALT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RS_MSB = 11;
   localparam int RS_LSB = 8;
   localparam int RT_MSB = 7;
   localparam int RT_LSB = 4;
   localparam int RD_MSB = 3;
   localparam int RD_LSB = 0;

   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   // Opcodes 0..5 are the ALU group: they write rd from the ALU and update flags.
   function automatic logic is_alu_op(logic [3:0] op);
      return op <= 4'd5;
   endfunction

endpackage

// File: rtl/mgt_regfile.sv
// 16-entry register file, two combinational read ports and one write port;
// r0 always reads zero and discards writes.
module mgt_regfile #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [3:0]        ra_addr,
   input  logic [3:0]        rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   input  logic              wr_en,
   input  logic [3:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data = regs_q[ra_addr];
   assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/mgt_core_mc.sv
// Multi-cycle MGT core: handshaked instruction fetch, FSM sequencing and a
// shared bidirectional data-memory bus with wait-state tolerance.
//
// state    | meaning
// FETCH    | instr_req high, wait for instr_valid, latch IR
// DECODE   | latch operands A (rs) and B (rt)
// EXEC     | ALU / compare / address; rd data read for ST
// MEM      | bus access held until mem_ready
// WB       | register write and pc update
// HALT     | terminal until reset
module mgt_core_mc
   import mgt_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   output logic              instr_req,
   output logic [PC_W-1:0]   pc,
   input  logic [15:0]       instruction,
   input  logic              instr_valid,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              n_mem_cs,
   output logic              n_mem_rw,
   output logic              n_mem_oe,
   input  logic              mem_ready,
   output logic [2:0]        flags,
   output logic              halted
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc, pc_next;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, dout_q, dout_d;
   logic              eq_q, eq_d, drive_q, drive_d;
   logic [2:0]        flags_q, flags_d;
   logic              cs_n_q, cs_n_d, oe_n_q, oe_n_d, rw_n_q, rw_n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [3:0]        op, rs, rt, rd, ra_addr;
   logic              is_ld, is_st, rf_we;
   logic [DATA_W-1:0] ra_data, rb_data, alu_res;
   logic              alu_c;
   logic [DATA_W:0]   alu_sum, alu_dif;

   assign op    = ir_q[OP_MSB:OP_LSB];
   assign rs    = ir_q[RS_MSB:RS_LSB];
   assign rt    = ir_q[RT_MSB:RT_LSB];
   assign rd    = ir_q[RD_MSB:RD_LSB];
   assign is_ld = (op == OP_LD);
   assign is_st = (op == OP_ST);

   // Port A reads rd in EXEC so ST data is available with only two read ports.
   assign ra_addr = (state_q == S_EXEC) ? rd : rs;
   assign rf_we   = (state_q == S_WB) && (is_alu_op(op) || is_ld || op == OP_LI);

   mgt_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk     (clk),
      .n_reset (n_reset),
      .ra_addr (ra_addr),
      .rb_addr (rt),
      .ra_data (ra_data),
      .rb_data (rb_data),
      .wr_en   (rf_we),
      .wr_addr (rd),
      .wr_data (res_q)
   );

   always_comb begin
      alu_sum = {1'b0, a_q} + {1'b0, b_q};
      alu_dif = {1'b0, a_q} - {1'b0, b_q};
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_ADD:  {alu_c, alu_res} = alu_sum;
         OP_SUB:  {alu_c, alu_res} = alu_dif;
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SLT:  alu_res = DATA_W'(a_q < b_q);
         OP_LI:   alu_res = DATA_W'(ir_q[RS_MSB:RT_LSB]);
         default: ;
      endcase
   end

   always_comb begin
      pc_inc = pc_q + PC_W'(1);
      case (op)
         OP_JMP:  pc_next = PC_W'(ir_q[RS_MSB:RT_LSB]);
         OP_BEQ:  pc_next = eq_q ? pc_inc + PC_W'($signed(ir_q[RD_MSB:RD_LSB])) : pc_inc;
         default: pc_next = pc_inc;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (instr_valid) state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (is_ld || is_st)      state_d = S_MEM;
            else if (op == OP_HALT)  state_d = S_HALT;
            else                     state_d = S_WB;
         end
         S_MEM:    if (mem_ready) state_d = S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      eq_d    = eq_q;
      flags_d = flags_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      case (state_q)
         S_FETCH:  if (instr_valid) ir_d = instruction;
         S_DECODE: begin
            a_d = ra_data;
            b_d = rb_data;
         end
         S_EXEC: begin
            res_d = alu_res;
            eq_d  = (a_q == b_q);
            if (is_alu_op(op)) begin
               flags_d[FLAG_N] = alu_res[DATA_W-1];
               flags_d[FLAG_C] = alu_c;
               flags_d[FLAG_Z] = (alu_res == '0);
            end
            if (is_ld || is_st) begin
               addr_d = ADDR_W'(alu_sum);
               dout_d = ra_data;
            end
         end
         S_MEM:    if (mem_ready && is_ld) res_d = mem_data;
         S_WB:     pc_d = pc_next;
         default:  ;
      endcase
   end

   // Bus controls are decoded from the next state so they leave flops directly.
   always_comb begin
      cs_n_d  = (state_d != S_MEM);
      oe_n_d  = !((state_d == S_MEM) && is_ld);
      rw_n_d  = !((state_d == S_MEM) && is_st);
      drive_d = (state_d == S_MEM) && is_st;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         eq_q    <= 1'b0;
         flags_q <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         cs_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         rw_n_q  <= 1'b1;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         eq_q    <= eq_d;
         flags_q <= flags_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         cs_n_q  <= cs_n_d;
         oe_n_q  <= oe_n_d;
         rw_n_q  <= rw_n_d;
         drive_q <= drive_d;
      end
   end

   // Output logic
   always_comb begin
      instr_req = (state_q == S_FETCH);
      halted    = (state_q == S_HALT);
      pc        = pc_q;
      flags     = flags_q;
      mem_addr  = addr_q;
      n_mem_cs  = cs_n_q;
      n_mem_oe  = oe_n_q;
      n_mem_rw  = rw_n_q;
   end

   assign mem_data = drive_q ? dout_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mgt_core_mc.sv
// Bench for mgt_core_mc: ALU vector table, hand-written multi-cycle sequences
// and random instruction streams checked against an ISA-level model.
module tb_mgt_core_mc;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        instr_req;
   logic [7:0]  pc;
   logic [15:0] instruction;
   logic        instr_valid;
   logic [7:0]  mem_addr;
   wire  [7:0]  mem_data;
   logic        n_mem_cs, n_mem_rw, n_mem_oe;
   logic        mem_ready;
   logic [2:0]  flags;
   logic        halted;

   logic [7:0]  dmem [256];

   int n_cmp = 0;
   int n_err = 0;

   int mregs [16];
   int mmem  [256];
   int mpc, mflags;
   bit mhalt;

   bit obs_st;
   int obs_st_addr, obs_st_data;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [2:0] fl;
   } vec_t;
   vec_t vt [11];

   mgt_core_mc dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .instr_req   (instr_req),
      .pc          (pc),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .n_mem_cs    (n_mem_cs),
      .n_mem_rw    (n_mem_rw),
      .n_mem_oe    (n_mem_oe),
      .mem_ready   (mem_ready),
      .flags       (flags),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign mem_data = (!n_mem_cs && !n_mem_oe) ? dmem[mem_addr] : 8'bz;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] li(input logic [3:0] rd, input logic [7:0] imm);
      return {4'd8, imm, rd};
   endfunction

   function automatic int flg(input int r, input int c);
      return ((r >> 7) & 1) * 4 + c * 2 + ((r == 0) ? 1 : 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mregs[i] = 0;
      mpc = 0; mflags = 0; mhalt = 0;
   endtask

   // ISA-level reference: architectural effect of one instruction.
   task automatic model_exec(input logic [15:0] ins, output int cyc, output bit st,
                             output int ea, output int ed);
      int op, rs, rt, rd, a, b, r, off;
      op = int'(ins[15:12]); rs = int'(ins[11:8]); rt = int'(ins[7:4]); rd = int'(ins[3:0]);
      a = mregs[rs]; b = mregs[rt];
      st = 0; ea = 0; ed = 0; cyc = 4; r = -1;
      case (op)
         0: begin r = (a + b) % 256; mflags = flg(r, (a + b > 255) ? 1 : 0); end
         1: begin r = (a - b + 256) % 256; mflags = flg(r, (a < b) ? 1 : 0); end
         2: begin r = a & b; mflags = flg(r, 0); end
         3: begin r = a | b; mflags = flg(r, 0); end
         4: begin r = a ^ b; mflags = flg(r, 0); end
         5: begin r = (a < b) ? 1 : 0; mflags = flg(r, 0); end
         6: begin cyc = 5; r = mmem[(a + b) % 256]; end
         7: begin cyc = 5; st = 1; ea = (a + b) % 256; ed = mregs[rd]; mmem[ea] = ed; end
         8: r = int'(ins[11:4]);
         default: ;
      endcase
      if (r >= 0 && rd != 0) mregs[rd] = r;
      if (op == 9) begin
         off = (rd > 7) ? rd - 16 : rd;
         mpc = (a == b) ? ((mpc + 1 + off) % 256 + 256) % 256 : (mpc + 1) % 256;
      end else if (op == 10) begin
         mpc = int'(ins[11:4]);
      end else if (op == 15) begin
         cyc = 3; mhalt = 1;
      end else begin
         mpc = (mpc + 1) % 256;
      end
   endtask

   task automatic do_reset();
      n_reset = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; instruction = '0;
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      model_reset();
   endtask

   // Runs one instruction from a FETCH-state negedge to the next FETCH (or HALT).
   task automatic exec(input logic [15:0] ins, input int waits, input int vdelay);
      int cyc, cs_cyc, wl, exp_cyc, ea, ed, op;
      bit ctrl_bad, est;
      op = int'(ins[15:12]);
      chk("fetch_ready", int'(instr_req), 1);
      instr_valid = 1'b0;
      for (int i = 0; i < vdelay; i++) begin
         instruction = 16'($urandom);
         @(negedge clk);
         if (i == vdelay - 1) begin
            chk("stall_pc", int'(pc), mpc);
            chk("stall_req", int'(instr_req), 1);
         end
      end
      instr_valid = 1'b1; instruction = ins;
      cyc = 0; cs_cyc = 0; wl = waits; ctrl_bad = 0; obs_st = 0;
      do begin
         if (!n_mem_cs) begin
            cs_cyc++;
            mem_ready = (wl == 0);
            if (op == 7) begin
               if (n_mem_rw || !n_mem_oe) ctrl_bad = 1;
            end else begin
               if (!n_mem_rw || n_mem_oe) ctrl_bad = 1;
            end
            if (wl == 0 && !n_mem_rw) begin
               obs_st = 1; obs_st_addr = int'(mem_addr); obs_st_data = int'(mem_data);
               dmem[mem_addr] = mem_data;
            end
            wl--;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
         instr_valid = 1'($urandom_range(0, 1));
         instruction = 16'($urandom);
      end while (!instr_req && !halted && cyc < 40);
      mem_ready = 1'b0;
      model_exec(ins, exp_cyc, est, ea, ed);
      if (op == 6 || op == 7) exp_cyc += waits;
      chk("cycles", cyc, exp_cyc);
      chk("cs_cycles", cs_cyc, (op == 6 || op == 7) ? waits + 1 : 0);
      chk("pc", int'(pc), mpc);
      chk("flags", int'(flags), mflags);
      chk("halted", int'(halted), int'(mhalt));
      if (op == 6 || op == 7) chk("bus_ctrl", int'(ctrl_bad), 0);
      if (est) begin
         chk("st_seen", int'(obs_st), 1);
         chk("st_addr", obs_st_addr, ea);
         chk("st_data", obs_st_data, ed);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      vt[0]  = '{4'd0, 8'h05, 8'h03, 8'h08, 3'b000};
      vt[1]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 3'b011};
      vt[2]  = '{4'd0, 8'h7F, 8'h01, 8'h80, 3'b100};
      vt[3]  = '{4'd0, 8'h80, 8'h80, 8'h00, 3'b011};
      vt[4]  = '{4'd1, 8'h03, 8'h05, 8'hFE, 3'b110};
      vt[5]  = '{4'd1, 8'h05, 8'h05, 8'h00, 3'b001};
      vt[6]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 3'b000};
      vt[7]  = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 3'b100};
      vt[8]  = '{4'd4, 8'hAA, 8'hAA, 8'h00, 3'b001};
      vt[9]  = '{4'd5, 8'h03, 8'h05, 8'h01, 3'b000};
      vt[10] = '{4'd5, 8'hFF, 8'h01, 8'h00, 3'b001};

      for (int i = 0; i < 256; i++) begin
         dmem[i] = 8'($urandom);
         mmem[i] = int'(dmem[i]);
      end

      do_reset();
      #1;
      chk("rst_instr_req", int'(instr_req), 1);
      chk("rst_pc", int'(pc), 0);
      chk("rst_flags", int'(flags), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_cs", int'(n_mem_cs), 1);
      chk("rst_oe", int'(n_mem_oe), 1);
      chk("rst_rw", int'(n_mem_rw), 1);
      chk("rst_addr", int'(mem_addr), 0);

      // ALU vector table; result observed by storing r3 to address 0.
      for (int i = 0; i < 11; i++) begin
         exec(li(4'd1, vt[i].a), 0, 0);
         exec(li(4'd2, vt[i].b), 0, 0);
         exec({vt[i].op, 4'd1, 4'd2, 4'd3}, 0, 0);
         if (i == 0) chk("pc_after_3", int'(pc), 3);
         chk("vec_flags", int'(flags), int'(vt[i].fl));
         exec({4'd7, 4'd0, 4'd0, 4'd3}, 0, 0);
         chk("vec_res", obs_st_data, int'(vt[i].res));
      end

      // ST with three wait states, then LD back.
      exec(li(4'd3, 8'hA5), 0, 0);
      exec(li(4'd1, 8'h0C), 0, 0);
      exec(li(4'd2, 8'h04), 0, 0);
      exec({4'd7, 4'd1, 4'd2, 4'd3}, 3, 0);
      chk("st_addr_10", obs_st_addr, 'h10);
      chk("st_data_a5", obs_st_data, 'hA5);
      exec({4'd6, 4'd1, 4'd2, 4'd4}, 2, 0);
      exec({4'd7, 4'd0, 4'd0, 4'd4}, 0, 0);
      chk("ld_r4", obs_st_data, 'hA5);

      // Branch backwards and pc wrap.
      exec({4'd10, 8'h05, 4'd0}, 0, 0);
      chk("jmp_pc5", int'(pc), 5);
      exec({4'd9, 4'd0, 4'd0, 4'hE}, 0, 0);
      chk("beq_pc4", int'(pc), 4);
      exec({4'd10, 8'hFF, 4'd0}, 0, 0);
      chk("jmp_pcff", int'(pc), 'hFF);
      exec({4'd11, 12'h000}, 0, 5);
      chk("wrap_pc0", int'(pc), 0);

      for (int n = 0; n < 300; n++)
         exec({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 2));

      // Reset asserted while an LD waits in MEM.
      do_reset();
      dmem[8'h21] = 8'h5A; mmem['h21] = 'h5A;
      exec(li(4'd7, 8'h21), 0, 0);
      instruction = {4'd6, 4'd7, 4'd0, 4'd6}; instr_valid = 1'b1; mem_ready = 1'b0;
      k = 0;
      while (n_mem_cs && k < 10) begin
         @(negedge clk);
         instr_valid = 1'b0;
         k++;
      end
      chk("ld_reached_mem", int'(n_mem_cs), 0);
      chk("ld_oe_low", int'(n_mem_oe), 0);
      chk("ld_addr_21", int'(mem_addr), 'h21);
      repeat (2) @(negedge clk);
      #2 n_reset = 1'b0;
      #1;
      chk("midrst_cs", int'(n_mem_cs), 1);
      chk("midrst_oe", int'(n_mem_oe), 1);
      chk("midrst_rw", int'(n_mem_rw), 1);
      chk("midrst_addr", int'(mem_addr), 0);
      chk("midrst_pc", int'(pc), 0);
      chk("midrst_req", int'(instr_req), 1);
      @(negedge clk);
      n_reset = 1'b1;
      model_reset();
      exec({4'd7, 4'd0, 4'd0, 4'd6}, 0, 0);
      chk("ld_abort_r6", obs_st_data, 0);

      // HALT is terminal.
      exec(li(4'd1, 8'h11), 0, 0);
      exec({4'd15, 12'h000}, 0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         instr_valid = 1'($urandom_range(0, 1));
         chk("halt_stays", int'(halted), 1);
         chk("halt_no_req", int'(instr_req), 0);
         chk("halt_pc", int'(pc), mpc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
